// File: rtl/ips2l_cmd_parser_burst.sv
// Byte-stream command parser for the UART debug path: decodes single/burst
// read/write frames and drives a one-command-at-a-time access port.
module ips2l_cmd_parser_burst #(
  parameter int ADDR_BYTES  = 3,
  parameter int DATA_BYTES  = 4,
  parameter int TIMEOUT_CYC = 65535,
  localparam int AW = 8 * ADDR_BYTES,
  localparam int DW = 8 * DATA_BYTES
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    fifo_data,
  input  logic          fifo_data_valid,
  output logic          fifo_data_req,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  output logic          we,
  output logic          cmd_en,
  input  logic          cmd_done,
  output logic          busy,
  output logic          err_timeout
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CMD  = 3'd4;
  localparam logic [2:0] S_WAIT = 3'd5;

  localparam logic [23:0] TMO_LIM   = 24'(TIMEOUT_CYC);
  localparam logic [2:0]  ADDR_LAST = 3'(ADDR_BYTES - 1);
  localparam logic [2:0]  DATA_LAST = 3'(DATA_BYTES - 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    len_q, len_d;
  logic          wr_q, wr_d;
  logic          burst_q, burst_d;
  logic [23:0]   tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          in_field;
  logic          accept;

  assign in_field      = (state_q == S_ADDR) || (state_q == S_LEN) || (state_q == S_DATA);
  assign fifo_data_req = fifo_data_valid && ((state_q == S_IDLE) || in_field);
  assign accept        = fifo_data_req;

  assign addr        = addr_q;
  assign data        = data_q;
  assign cmd_en      = (state_q == S_CMD);
  assign we          = (state_q == S_CMD) && wr_q;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    bcnt_d  = bcnt_q;
    len_d   = len_q;
    wr_d    = wr_q;
    burst_d = burst_q;
    tmo_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Unknown header bytes are popped and dropped without complaint.
        if (accept) begin
          bcnt_d = '0;
          len_d  = '0;
          case (fifo_data)
            8'h77: begin wr_d = 1'b1; burst_d = 1'b0; state_d = S_ADDR; end
            8'h72: begin wr_d = 1'b0; burst_d = 1'b0; state_d = S_ADDR; end
            8'h57: begin wr_d = 1'b1; burst_d = 1'b1; state_d = S_ADDR; end
            8'h52: begin wr_d = 1'b0; burst_d = 1'b1; state_d = S_ADDR; end
            default: ;
          endcase
        end
      end
      S_ADDR: begin
        if (accept) begin
          for (int k = 0; k < ADDR_BYTES; k++) begin
            if (bcnt_q == 3'(k)) addr_d[8*k +: 8] = fifo_data;
          end
          if (bcnt_q == ADDR_LAST) begin
            bcnt_d  = '0;
            state_d = burst_q ? S_LEN : (wr_q ? S_DATA : S_CMD);
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end
      end
      S_LEN: begin
        if (accept) begin
          len_d   = fifo_data;
          state_d = wr_q ? S_DATA : S_CMD;
        end
      end
      S_DATA: begin
        if (accept) begin
          for (int k = 0; k < DATA_BYTES; k++) begin
            if (bcnt_q == 3'(k)) data_d[8*k +: 8] = fifo_data;
          end
          if (bcnt_q == DATA_LAST) begin
            bcnt_d  = '0;
            state_d = S_CMD;
          end else begin
            bcnt_d = bcnt_q + 3'd1;
          end
        end
      end
      S_CMD: state_d = S_WAIT;
      S_WAIT: begin
        // len_q holds the number of words still to go after the current one.
        if (cmd_done) begin
          if (len_q != 8'd0) begin
            len_d   = len_q - 8'd1;
            addr_d  = addr_q + AW'(1);
            state_d = wr_q ? S_DATA : S_CMD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Inter-byte timeout only runs while a frame is being collected.
    if (in_field && !fifo_data_valid && (TIMEOUT_CYC != 0)) begin
      if (tmo_q == TMO_LIM - 24'd1) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 24'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      bcnt_q  <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
      burst_q <= 1'b0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      bcnt_q  <= bcnt_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      burst_q <= burst_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ips2l_cmd_parser_burst.sv
// Scoreboard bench for ips2l_cmd_parser_burst: one instance with a short
// timeout (3/4 byte fields) and one with 4-byte address / 2-byte data.
module tb_ips2l_cmd_parser_burst;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       valid = 1'b0;
  logic       sel2 = 1'b0;
  logic       man_done = 1'b0;
  logic       auto_en = 1'b1;
  logic       auto_done_q = 1'b0;
  int         done_dly = 3;
  int         dcnt = 0;
  int         cyc = 0;
  int         err_cnt = 0;
  int         consec_cnt = 0;
  logic       prev_en = 1'b0;
  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];
  obs_t       obs_q[$];

  always #5 clk = ~clk;

  logic        req1, we1, en1, busy1, err1;
  logic [23:0] addr1;
  logic [31:0] data1;
  logic        req2, we2, en2, busy2, err2;
  logic [31:0] addr2;
  logic [15:0] data2;
  logic        cmd_done;

  assign cmd_done = auto_en ? auto_done_q : man_done;

  ips2l_cmd_parser_burst #(.ADDR_BYTES(3), .DATA_BYTES(4), .TIMEOUT_CYC(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_data_valid(valid & ~sel2),
    .fifo_data_req(req1), .addr(addr1), .data(data1), .we(we1), .cmd_en(en1),
    .cmd_done(cmd_done & ~sel2), .busy(busy1), .err_timeout(err1));

  ips2l_cmd_parser_burst #(.ADDR_BYTES(4), .DATA_BYTES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .fifo_data(fifo_data), .fifo_data_valid(valid & sel2),
    .fifo_data_req(req2), .addr(addr2), .data(data2), .we(we2), .cmd_en(en2),
    .cmd_done(cmd_done & sel2), .busy(busy2), .err_timeout(err2));

  logic        m_req, m_we, m_en, m_busy, m_err;
  logic [31:0] m_addr, m_data;
  assign m_req  = sel2 ? req2  : req1;
  assign m_we   = sel2 ? we2   : we1;
  assign m_en   = sel2 ? en2   : en1;
  assign m_busy = sel2 ? busy2 : busy1;
  assign m_err  = sel2 ? err2  : err1;
  assign m_addr = sel2 ? addr2 : {8'h00, addr1};
  assign m_data = sel2 ? {16'h0000, data2} : data1;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every command strobe; the test tasks compare against the expected queue.
  always @(negedge clk) begin
    if (rst_n && m_en) begin
      obs_q.push_back('{m_we, m_addr, m_data, cyc});
      if (prev_en) consec_cnt <= consec_cnt + 1;
    end
    if (rst_n && m_err) err_cnt <= err_cnt + 1;
    prev_en <= m_en;
  end

  // Access-port model: answers each cmd_en with a cmd_done done_dly cycles later.
  always @(negedge clk) begin
    auto_done_q <= 1'b0;
    if (dcnt > 1) dcnt <= dcnt - 1;
    else if (dcnt == 1) begin
      dcnt        <= 0;
      auto_done_q <= 1'b1;
    end
    if (auto_en && m_en) dcnt <= done_dly;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    fifo_data = b;
    valid     = 1'b1;
    #1;
    while (!m_req && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!m_req) begin
      checks++; errors++;
      $display("FAIL send_byte: req for byte %02h got 0, need 1", b);
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic send_frame(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(v[8*i +: 8]);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_busy && n < 1000);
    checks++;
    if (m_busy) begin
      errors++;
      $display("FAIL wait_idle: busy got 1, need 0 within 1000 cycles");
    end
  endtask

  task automatic test_reset();
    valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({en1, we1, busy1, err1, addr1, data1} !== '0) begin
      errors++;
      $display("FAIL reset_outs: en/we/busy/err/addr/data got %b%b%b%b %h %h, need all 0",
               en1, we1, busy1, err1, addr1, data1);
    end
    checks++;
    if (req1 !== 1'b1) begin errors++; $display("FAIL reset_req: got %b need 1", req1); end
    valid = 1'b0;
    #1;
    checks++;
    if (req1 !== 1'b0) begin errors++; $display("FAIL reset_req_low: got %b need 0", req1); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_default_write();
    exp_t e;
    obs_t o;
    done_dly = 3;
    exp_q.push_back('{1'b1, 32'h00302010, 32'hDDCCBBAA, 1'b1});
    send_frame(128'hDDCCBBAA_30201077, 8);
    checks++;
    if (m_en !== 1'b1 || m_we !== 1'b1) begin
      errors++;
      $display("FAIL dflt_latency: cmd_en/we got %b/%b, need 1/1 the cycle after last byte", m_en, m_we);
    end
    wait_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL dflt_cmd: got no cmd_en, need addr %h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data) begin
          errors++;
          $display("FAIL dflt_cmd: got we=%b addr=%h data=%h, need we=%b addr=%h data=%h",
                   o.we, o.addr, o.data, e.we, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic test_single_read();
    exp_t e;
    obs_t o;
    auto_en = 1'b0;
    exp_q.push_back('{1'b0, 32'h00000001, 32'h0, 1'b0});
    send_frame(128'h00000172, 4);
    checks++;
    if (m_en !== 1'b1 || m_we !== 1'b0) begin
      errors++; $display("FAIL read_cmd_cycle: cmd_en/we got %b/%b, need 1/0", m_en, m_we);
    end
    man_done = 1'b1;
    @(posedge clk);
    #1;
    man_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (m_busy !== 1'b1) begin errors++; $display("FAIL read_done_in_cmd: busy got %b need 1", m_busy); end
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    checks++;
    if (m_busy !== 1'b0) begin errors++; $display("FAIL read_done_wait: busy got %b need 0", m_busy); end
    auto_en = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL read_cmd: got no cmd_en, need addr %h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o.we !== e.we || o.addr !== e.addr) begin
          errors++;
          $display("FAIL read_cmd: got we=%b addr=%h, need we=%b addr=%h", o.we, o.addr, e.we, e.addr);
        end
      end
    end
  endtask

  task automatic test_burst_write_wrap();
    exp_t e;
    obs_t o;
    done_dly = 2;
    exp_q.push_back('{1'b1, 32'h00FFFFFF, 32'h44332211, 1'b1});
    exp_q.push_back('{1'b1, 32'h00000000, 32'h88776655, 1'b1});
    send_frame(128'h88776655_44332211_01FFFFFF57, 13);
    wait_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL bwr_cmd: got no cmd_en, need addr %h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data) begin
          errors++;
          $display("FAIL bwr_cmd: got we=%b addr=%h data=%h, need we=%b addr=%h data=%h",
                   o.we, o.addr, o.data, e.we, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic test_burst_read();
    exp_t e;
    obs_t o;
    int   last_cyc = 0;
    bit   first = 1'b1;
    done_dly = 2;
    for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, 32'h00000100 + 32'(i), 32'h0, 1'b0});
    send_frame(128'h0300010052, 5);
    wait_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL brd_cmd: got no cmd_en, need addr %h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o.we !== e.we || o.addr !== e.addr) begin
          errors++;
          $display("FAIL brd_cmd: got we=%b addr=%h, need we=%b addr=%h", o.we, o.addr, e.we, e.addr);
        end
        if (!first) begin
          checks++;
          if (o.cyc != last_cyc + done_dly + 1) begin
            errors++;
            $display("FAIL brd_gap: cmd_en gap got %0d cycles, need %0d", o.cyc - last_cyc, done_dly + 1);
          end
        end
        first    = 1'b0;
        last_cyc = o.cyc;
      end
    end
  endtask

  task automatic test_reset_midframe();
    send_frame(128'h201077, 3);
    checks++;
    if (m_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b need 1", m_busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy1 !== 1'b0 || addr1 !== 24'h0 || en1 !== 1'b0 || err1 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outs: busy=%b addr=%h en=%b err=%b, need 0 0 0 0", busy1, addr1, en1, err1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_timeout_junk();
    exp_t e;
    obs_t o;
    int   e0 = err_cnt;
    send_byte(8'h41);
    @(negedge clk);
    checks++;
    if (m_busy !== 1'b0 || err_cnt != e0) begin
      errors++; $display("FAIL junk_byte: busy=%b errs=%0d, need busy 0 errs 0", m_busy, err_cnt - e0);
    end
    send_frame(128'h201077, 3);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (m_err !== (k == 9)) begin
        errors++; $display("FAIL tmo_pulse: cycle %0d err_timeout got %b need %b", k, m_err, (k == 9));
      end
    end
    checks++;
    if (m_busy !== 1'b0 || err_cnt - e0 != 1 || obs_q.size() != 0) begin
      errors++;
      $display("FAIL tmo_abort: busy=%b pulses=%0d cmds=%0d, need 0 1 0", m_busy, err_cnt - e0, obs_q.size());
    end
    done_dly = 2;
    exp_q.push_back('{1'b1, 32'h00030201, 32'h44332211, 1'b1});
    send_frame(128'h44332211_03020177, 8);
    wait_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL tmo_recover: got no cmd_en, need addr %h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data) begin
          errors++;
          $display("FAIL tmo_recover: got we=%b addr=%h data=%h, need we=%b addr=%h data=%h",
                   o.we, o.addr, o.data, e.we, e.addr, e.data);
        end
      end
    end
  endtask

  task automatic test_param_widths();
    exp_t e;
    obs_t o;
    sel2     = 1'b1;
    done_dly = 2;
    exp_q.push_back('{1'b1, 32'h04030201, 32'h00006655, 1'b1});
    send_frame(128'h6655_04030201_77, 7);
    wait_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL param_cmd: got no cmd_en, need addr %h", e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o.we !== e.we || o.addr !== e.addr || o.data !== e.data) begin
          errors++;
          $display("FAIL param_cmd: got we=%b addr=%h data=%h, need we=%b addr=%h data=%h",
                   o.we, o.addr, o.data, e.we, e.addr, e.data);
        end
      end
    end
    sel2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_write();
    test_single_read();
    test_burst_write_wrap();
    test_burst_read();
    test_reset_midframe();
    test_timeout_junk();
    test_param_widths();
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL stray_cmds: got %0d unexpected cmd_en, need 0", obs_q.size());
    end
    checks++;
    if (consec_cnt != 0) begin
      errors++; $display("FAIL cmd_en_back2back: got %0d consecutive strobes, need 0", consec_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ips2l_cmd_parser_burst.md
# ips2l_cmd_parser_burst

Parametrised byte-stream command parser for the UART debug path of the DDR3 example design. It consumes bytes from the UART RX FIFO, decodes single and burst read/write commands with configurable address and data widths, and drives a one-command-at-a-time register/memory access port. It also enforces an inter-byte timeout so a truncated frame cannot hang the parser.

## Interface
- ADDR_BYTES, 3, address bytes per frame (1..4); addr width AW = 8*ADDR_BYTES
- DATA_BYTES, 4, data bytes per word (1..8); data width DW = 8*DATA_BYTES
- TIMEOUT_CYC, 65535, inter-byte timeout in clk cycles (0 disables; max 2^24-1)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- fifo_data  in  8  RX FIFO head byte
- fifo_data_valid  in  1  head byte valid
- fifo_data_req  out  1  pop strobe; combinational = fifo_data_valid & parser in IDLE/ADDR/LEN/DATA
- addr  out  AW  command address, registered
- data  out  DW  write data, registered
- we  out  1  high with cmd_en for writes
- cmd_en  out  1  one-cycle command strobe
- cmd_done  in  1  access complete (single-cycle pulse)
- busy  out  1  state != IDLE
- err_timeout  out  1  one-cycle pulse on timeout abort

## Operation
- Frame: header, ADDR_BYTES address bytes, [LEN byte], data bytes. All multi-byte fields little-endian (first byte -> bits [7:0]).
- Headers: 0x77 'w' single write; 0x72 'r' single read; 0x57 'W' burst write; 0x52 'R' burst read. Other bytes in IDLE are popped and discarded silently; no error.
- Burst LEN byte L: L+1 words (1..256). Single commands behave as L=0.
- States: IDLE, ADDR, LEN, DATA, CMD, WAIT.
  - IDLE -> ADDR on valid header.
  - ADDR collects ADDR_BYTES bytes (byte counter), then -> LEN (burst), DATA (write), or CMD (read).
  - LEN -> DATA (burst write) or CMD (burst read).
  - DATA collects DATA_BYTES bytes into data[8k+:8], then -> CMD.
  - CMD -> WAIT unconditionally; cmd_en=1, we=1 for writes only.
  - WAIT: on cmd_done, if words remain: addr <= addr+1 (mod 2^AW), then -> DATA (write) or CMD (read). Else -> IDLE.
- Only a byte accepted (valid & req) advances a state or counter.
- addr/data hold from CMD until the next field byte overwrites them. data is not cleared between words; reads leave data at its last value.
- Timeout: counter clears on each accepted byte and on entry to ADDR. It increments each cycle in ADDR/LEN/DATA without valid. On reaching TIMEOUT_CYC: -> IDLE, err_timeout pulses, partial fields are discarded (addr/data keep their partial contents, no cmd_en). No timeout in IDLE, CMD or WAIT.

## Timing
- Reset values: state IDLE, addr 0, data 0, we 0, cmd_en 0, busy 0, err_timeout 0, counters 0. fifo_data_req follows fifo_data_valid while in IDLE.
- Last field byte accepted in cycle t -> cmd_en/we high in cycle t+1 with stable addr/data -> WAIT from t+2.
- cmd_done is honoured only in WAIT; a pulse during CMD or IDLE is ignored.
- Burst read: next cmd_en one cycle after cmd_done (CMD in t+1, incremented addr valid in the same cycle).
- Burst write: next word's bytes are accepted starting the cycle after cmd_done.
- cmd_en never asserts on two consecutive cycles.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values.

## Test plan
- Defaults. Stream 77 10 20 30 AA BB CC DD, cmd_done 3 cycles after cmd_en -> one cmd_en with we=1, addr=0x302010, data=0xDDCCBBAA, busy low after cmd_done.
- Single read. Stream 72 01 00 00 -> cmd_en=1, we=0, addr=0x000001. A cmd_done injected during the CMD cycle is ignored; parser stays in WAIT until a later cmd_done.
- Burst write wrap. Stream 57 FF FF FF 01 + two 4-byte words -> two cmd_en with addr 0xFFFFFF then 0x000000, each with its own data word.
- Burst read. Stream 52 00 01 00 03 -> four cmd_en, addr 0x000100..0x000103, each exactly one cycle after the prior cmd_done.
- Timeout and junk, TIMEOUT_CYC=8. Stream 41 (discarded, no err), 77 10 20, then idle -> err_timeout pulse 8 cycles after byte 20, no cmd_en. A following full 'w' frame executes normally.
- Parametrised, ADDR_BYTES=4, DATA_BYTES=2. Stream 77 01 02 03 04 55 66 -> addr=0x04030201, data=0x6655.
